// File: rtl/risp_ctrl_pkg.sv
// Shared command/state encodings for the RISP run controller.
package risp_ctrl_pkg;

    localparam int OP_WIDTH = 2;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_NOP   = 2'd0,
        OP_CLEAR = 2'd1,
        OP_RUN   = 2'd2,
        OP_RSVD  = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_STEP  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } run_state_t;

endpackage

// File: rtl/risp_step_timer.sv
// Loadable down-counter that spaces network steps; o_zero marks the end of a WAIT.
module risp_step_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != {WIDTH{1'b0}})) begin
            r_count <= r_count - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == {WIDTH{1'b0}});

endmodule

// File: rtl/risp_run_controller.sv
// Sequences CLEAR / RUN(n) host commands into net_clr / net_en pulses for a RISP network.
module risp_run_controller
    import risp_ctrl_pkg::*;
#(
    parameter int RUN_WIDTH   = 16,
    parameter int TIME_WIDTH  = 32,
    parameter int STEP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OP_WIDTH-1:0]   cmd_op,
    input  logic [RUN_WIDTH-1:0]  cmd_arg,
    input  logic                  halt,
    output logic                  net_en,
    output logic                  net_clr,
    output logic                  sample_valid,
    output logic                  run_done,
    output logic                  busy,
    output logic [TIME_WIDTH-1:0] time_count
);

    localparam int TIMER_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES - 1) : 1;
    localparam logic [TIMER_W-1:0]    TIMER_LOAD = TIMER_W'((STEP_CYCLES > 1) ? (STEP_CYCLES - 2) : 0);
    localparam logic [RUN_WIDTH-1:0]  RUN_ZERO   = {RUN_WIDTH{1'b0}};
    localparam logic [RUN_WIDTH-1:0]  RUN_ONE    = {{(RUN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TIME_WIDTH-1:0] TIME_ZERO  = {TIME_WIDTH{1'b0}};
    localparam logic [TIME_WIDTH-1:0] TIME_ONE   = {{(TIME_WIDTH-1){1'b0}}, 1'b1};

    run_state_t            r_state;
    run_state_t            w_state_nxt;
    logic [RUN_WIDTH-1:0]  r_remaining;
    logic [RUN_WIDTH-1:0]  w_rem_nxt;
    logic [TIME_WIDTH-1:0] r_time;
    logic [TIME_WIDTH-1:0] w_time_nxt;
    logic                  r_sample_valid;
    logic                  w_timer_load;
    logic                  w_timer_dec;
    logic                  w_timer_zero;

    generate
        if (STEP_CYCLES > 1) begin : g_timer
            risp_step_timer #(
                .WIDTH (TIMER_W)
            ) u_timer (
                .clk        (clk),
                .arstn      (arstn),
                .i_load     (w_timer_load),
                .i_load_val (TIMER_LOAD),
                .i_dec      (w_timer_dec),
                .o_zero     (w_timer_zero)
            );
        end else begin : g_no_timer
            // Every step follows the previous one directly, so the wait always expires.
            logic w_unused_timer_ctl;
            assign w_unused_timer_ctl = w_timer_load | w_timer_dec;
            assign w_timer_zero       = 1'b1;
        end
    endgenerate

    // Next-state, step bookkeeping and timer control.
    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_remaining;
        w_time_nxt   = r_time;
        w_timer_load = 1'b0;
        w_timer_dec  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op_t'(cmd_op))
                        OP_CLEAR: w_state_nxt = ST_CLEAR;
                        OP_RUN: begin
                            if (cmd_arg != RUN_ZERO) begin
                                w_state_nxt = ST_STEP;
                                w_rem_nxt   = cmd_arg;
                            end else begin
                                w_state_nxt = ST_DONE;
                            end
                        end
                        default: w_state_nxt = ST_IDLE;
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_time_nxt  = TIME_ZERO;
                w_state_nxt = ST_DONE;
            end
            ST_STEP: begin
                w_rem_nxt  = r_remaining - RUN_ONE;
                w_time_nxt = r_time + TIME_ONE;
                if ((r_remaining == RUN_ONE) || halt) begin
                    w_state_nxt = ST_DONE;
                end else if (STEP_CYCLES > 1) begin
                    w_state_nxt  = ST_WAIT;
                    w_timer_load = 1'b1;
                end else begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_WAIT: begin
                if (halt) begin
                    w_state_nxt = ST_DONE;
                end else if (w_timer_zero) begin
                    w_state_nxt = ST_STEP;
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_timer_dec = 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state        <= ST_IDLE;
            r_remaining    <= RUN_ZERO;
            r_time         <= TIME_ZERO;
            r_sample_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_remaining    <= w_rem_nxt;
            r_time         <= w_time_nxt;
            r_sample_valid <= (r_state == ST_STEP);
        end
    end

    assign cmd_ready    = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign net_en       = (r_state == ST_STEP);
    assign net_clr      = (r_state == ST_CLEAR);
    assign run_done     = (r_state == ST_DONE);
    assign sample_valid = r_sample_valid;
    assign time_count   = r_time;

endmodule

// File: tb/tb_risp_run_controller.sv
// Directed bench: three controllers (STEP_CYCLES 1, 3, 4) checked against hand-computed cycle masks.
module tb_risp_run_controller;
    import risp_ctrl_pkg::*;

    logic        clk;
    logic        arstn;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        halt;
    logic        cmd_valid    [3];
    logic        cmd_ready    [3];
    logic        net_en       [3];
    logic        net_clr      [3];
    logic        sample_valid [3];
    logic        run_done     [3];
    logic        busy         [3];
    logic [31:0] time_count   [3];

    int n_checks;
    int n_errors;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int SC = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        risp_run_controller #(
            .RUN_WIDTH   (16),
            .TIME_WIDTH  (32),
            .STEP_CYCLES (SC)
        ) u_dut (
            .clk          (clk),
            .arstn        (arstn),
            .cmd_valid    (cmd_valid[g]),
            .cmd_ready    (cmd_ready[g]),
            .cmd_op       (cmd_op),
            .cmd_arg      (cmd_arg),
            .halt         (halt),
            .net_en       (net_en[g]),
            .net_clr      (net_clr[g]),
            .sample_valid (sample_valid[g]),
            .run_done     (run_done[g]),
            .busy         (busy[g]),
            .time_count   (time_count[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int idx, input logic [1:0] op, input logic [15:0] arg);
        @(negedge clk);
        cmd_valid[idx] = 1'b1;
        cmd_op         = op;
        cmd_arg        = arg;
    endtask

    // Bit i of each mask is the output in the i-th cycle after the accepting edge.
    task automatic run_case(input string tag, input int idx, input int nc, input int drop_at,
                            input int halt_at, input logic [31:0] e_en, input logic [31:0] e_sv,
                            input logic [31:0] e_dn, input logic [31:0] e_clr, input logic [31:0] e_rdy);
        logic [31:0] en_t, sv_t, dn_t, clr_t, rdy_t;
        en_t = 32'h0; sv_t = 32'h0; dn_t = 32'h0; clr_t = 32'h0; rdy_t = 32'h0;
        for (int i = 0; i < nc; i++) begin
            @(negedge clk);
            en_t[i]  = net_en[idx];
            sv_t[i]  = sample_valid[idx];
            dn_t[i]  = run_done[idx];
            clr_t[i] = net_clr[idx];
            rdy_t[i] = cmd_ready[idx];
            if (i == drop_at) cmd_valid[idx] = 1'b0;
            if (i == halt_at) halt = 1'b1;
            else if (i == halt_at + 1) halt = 1'b0;
        end
        check_val({tag, "_net_en"}, en_t, e_en);
        check_val({tag, "_sample_valid"}, sv_t, e_sv);
        check_val({tag, "_run_done"}, dn_t, e_dn);
        check_val({tag, "_net_clr"}, clr_t, e_clr);
        check_val({tag, "_cmd_ready"}, rdy_t, e_rdy);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        arstn    = 1'b1;
        cmd_op   = 2'd0;
        cmd_arg  = 16'd0;
        halt     = 1'b0;
        for (int i = 0; i < 3; i++) cmd_valid[i] = 1'b0;
        #2 arstn = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_val("rst_ready", {31'd0, cmd_ready[i]}, 32'd1);
            check_val("rst_busy", {31'd0, busy[i]}, 32'd0);
            check_val("rst_outs", {28'd0, net_en[i], net_clr[i], sample_valid[i], run_done[i]}, 32'd0);
            check_val("rst_time", time_count[i], 32'd0);
        end
        repeat (2) @(negedge clk);
        arstn = 1'b1;

        // S=1, RUN(4): four back-to-back steps, done after the last.
        send(0, OP_RUN, 16'd4);
        run_case("s1_run4", 0, 8, 0, -1, 32'h0F, 32'h1E, 32'h10, 32'h0, 32'hE0);
        check_val("s1_run4_time", time_count[0], 32'd4);

        // S=3, RUN(3): steps at k+1, k+4, k+7, done at k+8.
        send(1, OP_RUN, 16'd3);
        run_case("s3_run3", 1, 10, 0, -1, 32'h49, 32'h92, 32'h80, 32'h0, 32'h300);
        check_val("s3_run3_time", time_count[1], 32'd3);

        // S=1, RUN(5) then CLEAR.
        send(0, OP_RUN, 16'd5);
        run_case("s1_run5", 0, 7, 0, -1, 32'h1F, 32'h3E, 32'h20, 32'h0, 32'h40);
        check_val("s1_run5_time", time_count[0], 32'd9);
        send(0, OP_CLEAR, 16'd7);
        run_case("s1_clear", 0, 4, 0, -1, 32'h0, 32'h0, 32'h2, 32'h1, 32'hC);
        check_val("s1_clear_time", time_count[0], 32'd0);

        // S=4, RUN(10) halted in the WAIT after the second step.
        send(2, OP_RUN, 16'd10);
        run_case("s4_halt", 2, 10, 0, 5, 32'h11, 32'h22, 32'h40, 32'h0, 32'h380);
        check_val("s4_halt_time", time_count[2], 32'd2);

        // RUN(0), NOP, then RUN(2) with cmd_valid held until ready returns.
        send(0, OP_RUN, 16'd0);
        run_case("s1_run0", 0, 3, 0, -1, 32'h0, 32'h0, 32'h1, 32'h0, 32'h6);
        send(0, OP_NOP, 16'd9);
        run_case("s1_nop", 0, 3, 0, -1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h7);
        send(0, OP_RUN, 16'd2);
        run_case("s1_hold", 0, 6, 3, -1, 32'h3, 32'h6, 32'h4, 32'h0, 32'h38);
        check_val("s1_hold_time", time_count[0], 32'd2);

        // Asynchronous reset during the WAIT of RUN(8) on the S=3 controller.
        send(1, OP_RUN, 16'd8);
        run_case("s3_pre_rst", 1, 2, 0, -1, 32'h1, 32'h2, 32'h0, 32'h0, 32'h0);
        check_val("s3_pre_rst_busy", {31'd0, busy[1]}, 32'd1);
        check_val("s3_pre_rst_time", time_count[1], 32'd4);
        #2 arstn = 1'b0;
        #1;
        check_val("mid_rst_outs", {28'd0, net_en[1], net_clr[1], sample_valid[1], run_done[1]}, 32'd0);
        check_val("mid_rst_busy", {31'd0, busy[1]}, 32'd0);
        check_val("mid_rst_ready", {31'd0, cmd_ready[1]}, 32'd1);
        check_val("mid_rst_time", time_count[1], 32'd0);
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        check_val("post_rst_ready", {31'd0, cmd_ready[1]}, 32'd1);
        check_val("post_rst_time", time_count[1], 32'd0);
        send(1, OP_RUN, 16'd1);
        run_case("s3_run1", 1, 3, 0, -1, 32'h1, 32'h2, 32'h2, 32'h0, 32'h4);
        check_val("s3_run1_time", time_count[1], 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
